// File: rtl/containment_alert_scheduler_if.sv
// Request/alert bundle between the requesters and the containment alert scheduler.
// Handshake: a requester raises req_valid[i] with req_level[2i+1:2i] and holds both stable
// until it sees the one-cycle req_ack[i] pulse; the request is consumed on that pulse.
interface containment_alert_scheduler_if #(
  parameter int NREQ    = 3,
  parameter int TIMER_W = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [2*NREQ-1:0]  req_level;
  logic               breach;
  logic [NREQ-1:0]    req_ack;
  logic               green;
  logic               yellow;
  logic               red;
  logic [1:0]         level;
  logic               lockdown;
  logic [TIMER_W-1:0] dwell;
  logic [1:0]         state;

  modport master (
    output req_valid, req_level, breach,
    input  req_ack, green, yellow, red, level, lockdown, dwell, state
  );

  modport slave (
    input  req_valid, req_level, breach,
    output req_ack, green, yellow, red, level, lockdown, dwell, state
  );
endinterface

// File: rtl/containment_alert_scheduler.sv
// Alert-level arbiter for the containment core: immediate escalation, one-step dwell-gated
// de-escalation, breach-forced lockdown. State is exported on bus.state for debug.
module containment_alert_scheduler #(
  parameter int NREQ      = 3,
  parameter int MIN_DWELL = 10,
  parameter int TIMER_W   = 8
) (
  input  logic clock,
  input  logic rst_n,
  containment_alert_scheduler_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_GREEN    = 2'd0,
    ST_YELLOW   = 2'd1,
    ST_RED      = 2'd2,
    ST_LOCKDOWN = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   last, win;
  logic [1:0]         win_lvl, cur_lvl;
  logic               found, ack_nxt, clear_dwell;
  logic [TIMER_W-1:0] dwell_q;
  int                 idx;

  function automatic logic [1:0] lvl_of(input state_t s);
    case (s)
      ST_GREEN:  lvl_of = 2'd1;
      ST_YELLOW: lvl_of = 2'd2;
      default:   lvl_of = 2'd3;
    endcase
  endfunction

  function automatic state_t st_of(input logic [1:0] l);
    case (l)
      2'd1:    st_of = ST_GREEN;
      2'd2:    st_of = ST_YELLOW;
      default: st_of = ST_RED;
    endcase
  endfunction

  assign cur_lvl   = lvl_of(state);
  assign bus.dwell = dwell_q;
  assign bus.state = state;

  // Scan in round-robin order from last+1; a strictly higher level displaces the current
  // pick, so among equal levels the first one in scan order keeps the grant.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_lvl = 2'd0;
    idx     = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(last) + 1 + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[idx] && (!found || bus.req_level[2*idx +: 2] > win_lvl)) begin
        found   = 1'b1;
        win     = IDX_W'(idx);
        win_lvl = bus.req_level[2*idx +: 2];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ack_nxt     = 1'b0;
    clear_dwell = 1'b0;
    if (bus.breach) begin
      state_nxt   = ST_LOCKDOWN;
      clear_dwell = 1'b1;
    end else if (state == ST_LOCKDOWN) begin
      state_nxt   = ST_RED;
      clear_dwell = 1'b1;
    end else if (found) begin
      if (win_lvl == 2'd0 || win_lvl == cur_lvl) begin
        ack_nxt = 1'b1;
      end else if (win_lvl > cur_lvl) begin
        state_nxt   = st_of(win_lvl);
        clear_dwell = 1'b1;
        ack_nxt     = 1'b1;
      end else if (dwell_q >= TIMER_W'(MIN_DWELL)) begin
        // Only one step down even when the target is further below.
        state_nxt   = st_of(cur_lvl - 2'd1);
        clear_dwell = 1'b1;
        ack_nxt     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_GREEN;
      last         <= IDX_W'(NREQ - 1);
      dwell_q      <= '0;
      bus.req_ack  <= '0;
      bus.green    <= 1'b1;
      bus.yellow   <= 1'b0;
      bus.red      <= 1'b0;
      bus.level    <= 2'd1;
      bus.lockdown <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ack_nxt) last <= win;
      if (clear_dwell)       dwell_q <= '0;
      else if (dwell_q != '1) dwell_q <= dwell_q + 1'b1;
      bus.req_ack  <= ack_nxt ? (NREQ'(1) << win) : '0;
      bus.green    <= (state_nxt == ST_GREEN);
      bus.yellow   <= (state_nxt == ST_YELLOW);
      bus.red      <= (state_nxt == ST_RED) || (state_nxt == ST_LOCKDOWN);
      bus.level    <= lvl_of(state_nxt);
      bus.lockdown <= (state_nxt == ST_LOCKDOWN);
    end
  end
endmodule

// File: tb/tb_containment_alert_scheduler.sv
// Directed bench for containment_alert_scheduler: reset, escalation, dwell gating,
// round-robin ties, breach lockdown, asynchronous reset and dwell saturation.
module tb_containment_alert_scheduler;
  logic clock;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [2:0] exp_q[$];
  logic [2:0] e;

  containment_alert_scheduler_if #(.NREQ(3), .TIMER_W(8)) bus ();

  containment_alert_scheduler #(.NREQ(3), .MIN_DWELL(10), .TIMER_W(8)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {green, yellow, red, level}
  task automatic check_lights(input string tag, input logic g, input logic y, input logic r,
                              input logic [1:0] l);
    check(tag, 32'({bus.green, bus.yellow, bus.red, bus.level}), 32'({g, y, r, l}));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_level = '0;
    bus.breach    = 1'b0;

    // 1. reset
    #23 rst_n = 1'b1;
    check_lights("rst_lights", 1, 0, 0, 2'd1);
    check("rst_lockdown", 32'(bus.lockdown), 32'd0);
    check("rst_dwell", 32'(bus.dwell), 32'd0);
    check("rst_ack", 32'(bus.req_ack), 32'd0);
    step();
    check("idle_dwell1", 32'(bus.dwell), 32'd1);
    step();
    check("idle_dwell2", 32'(bus.dwell), 32'd2);

    // 2. escalation green -> red
    bus.req_valid = 3'b001;
    bus.req_level = 6'b00_00_11;
    step();
    check_lights("esc_lights", 0, 0, 1, 2'd3);
    check("esc_ack", 32'(bus.req_ack), 32'b001);
    check("esc_dwell", 32'(bus.dwell), 32'd0);
    bus.req_valid = '0;
    step();
    check("esc_ack_pulse", 32'(bus.req_ack), 32'd0);
    check("esc_dwell1", 32'(bus.dwell), 32'd1);

    // 3. dwell gating: red -> yellow -> green, one step per request
    repeat (3) step();
    check("gate_dwell4", 32'(bus.dwell), 32'd4);
    bus.req_valid = 3'b010;
    bus.req_level = 6'b00_01_00;
    for (int i = 0; i < 6; i++) begin
      step();
      check("gate_wait_ack", 32'(bus.req_ack), 32'd0);
    end
    check("gate_dwell10", 32'(bus.dwell), 32'd10);
    check_lights("gate_still_red", 0, 0, 1, 2'd3);
    step();
    check_lights("gate_yellow", 0, 1, 0, 2'd2);
    check("gate_ack_y", 32'(bus.req_ack), 32'b010);
    check("gate_dwell0", 32'(bus.dwell), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("gate_wait_ack2", 32'(bus.req_ack), 32'd0);
    end
    step();
    check_lights("gate_green", 1, 0, 0, 2'd1);
    check("gate_ack_g", 32'(bus.req_ack), 32'b010);
    bus.req_valid = '0;

    // 4. round-robin ties after a fresh reset (last = 2)
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    bus.req_level = 6'b10_00_10;
    bus.req_valid = 3'b101;
    exp_q = '{3'b001, 3'b100};
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      check("rr_ack_a", 32'(bus.req_ack), 32'(e));
      bus.req_valid = bus.req_valid & ~e;
    end
    check_lights("rr_yellow", 0, 1, 0, 2'd2);
    bus.req_valid = 3'b001;
    step();
    check("rr_single", 32'(bus.req_ack), 32'b001);
    bus.req_valid = 3'b101;
    exp_q = '{3'b100, 3'b001};
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      check("rr_ack_b", 32'(bus.req_ack), 32'(e));
      bus.req_valid = bus.req_valid & ~e;
    end
    // level 0 request: acked, level unchanged
    bus.req_valid = 3'b010;
    bus.req_level = 6'b00_00_00;
    step();
    check("none_ack", 32'(bus.req_ack), 32'b010);
    check_lights("none_level", 0, 1, 0, 2'd2);
    bus.req_valid = '0;

    // 5. breach at yellow with req0 pending at red
    bus.breach    = 1'b1;
    bus.req_valid = 3'b001;
    bus.req_level = 6'b00_00_11;
    step();
    check_lights("brk_lights", 0, 0, 1, 2'd3);
    check("brk_lockdown", 32'(bus.lockdown), 32'd1);
    check("brk_ack", 32'(bus.req_ack), 32'd0);
    check("brk_dwell", 32'(bus.dwell), 32'd0);
    check("brk_state", 32'(bus.state), 32'd3);
    step();
    check("brk_hold_ack", 32'(bus.req_ack), 32'd0);
    check("brk_hold_dwell", 32'(bus.dwell), 32'd0);
    bus.breach = 1'b0;
    step();
    check("rel_lockdown", 32'(bus.lockdown), 32'd0);
    check_lights("rel_red", 0, 0, 1, 2'd3);
    check("rel_dwell", 32'(bus.dwell), 32'd0);
    check("rel_ack", 32'(bus.req_ack), 32'd0);
    step();
    check("rel_ack_req0", 32'(bus.req_ack), 32'b001);
    check("rel_level", 32'(bus.level), 32'd3);
    check("rel_dwell1", 32'(bus.dwell), 32'd1);
    bus.req_valid = '0;

    // 6. asynchronous reset between edges while red
    step();
    step();
    #3 rst_n = 1'b0;
    #1;
    check_lights("arst_lights", 1, 0, 0, 2'd1);
    check("arst_dwell", 32'(bus.dwell), 32'd0);
    check("arst_ack", 32'(bus.req_ack), 32'd0);
    check("arst_lockdown", 32'(bus.lockdown), 32'd0);
    #2 rst_n = 1'b1;
    step();
    check("arst_dwell1", 32'(bus.dwell), 32'd1);

    // dwell saturation
    repeat (254) step();
    check("sat_dwell", 32'(bus.dwell), 32'd255);
    step();
    check("sat_hold", 32'(bus.dwell), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
